// File: rtl/snes_controller_emulator.sv
// SNES controller emulator: presents a 16-button serial frame to the console on SNES_Latch/SNES_clk_1.
// Optional latch-absence timeout is built only when SNES_EMU_TIMEOUT_EN is defined.
module snes_controller_emulator #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk_100M,
    input  logic        rst,
    input  logic        SNES_Latch,
    input  logic        SNES_clk_1,
    input  logic [15:0] btn_input,
    output logic        SNES_Data,
    output logic        frame_done,
    output logic [4:0]  bit_index,
    output logic        link_active
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_sync_range
        $error("SYNC_STAGES must be in 2..4");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        LATCHED,
        SHIFT,
        DONE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] latch_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic                   latch_q;
    logic                   sclk_q;
    logic                   sclk_rise;
    logic [15:0]            shreg;
    logic                   timed_out;

    // Edge pulses are registered so that latch level and clock edge reach the FSM together.
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            latch_sync <= '0;
            sclk_sync  <= '0;
            latch_q    <= 1'b0;
            sclk_q     <= 1'b0;
            sclk_rise  <= 1'b0;
        end else begin
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], SNES_Latch};
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], SNES_clk_1};
            latch_q    <= latch_sync[SYNC_STAGES-1];
            sclk_q     <= sclk_sync[SYNC_STAGES-1];
            sclk_rise  <= sclk_sync[SYNC_STAGES-1] & ~sclk_q;
        end
    end

`ifdef SNES_EMU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic             latch_rise;
    logic [CNT_W-1:0] timeout_cnt;

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            latch_rise  <= 1'b0;
            timeout_cnt <= '0;
            link_active <= 1'b0;
        end else begin
            latch_rise <= latch_sync[SYNC_STAGES-1] & ~latch_q;
            if (latch_rise) begin
                timeout_cnt <= '0;
                link_active <= 1'b1;
            end else if (timeout_cnt != CNT_MAX) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end else begin
                link_active <= 1'b0;
            end
        end
    end

    always_comb begin
        timed_out = 1'b0;
        if (timeout_cnt == CNT_MAX && !latch_rise) begin
            timed_out = 1'b1;
        end
    end
`else
    assign timed_out   = 1'b0;
    assign link_active = 1'b1;
`endif

    always_ff @(posedge clk_100M) begin
        frame_done <= 1'b0;
        if (rst) begin
            state     <= IDLE;
            SNES_Data <= 1'b1;
            bit_index <= '0;
            shreg     <= '1;
        end else if (timed_out) begin
            state     <= IDLE;
            SNES_Data <= 1'b1;
            bit_index <= '0;
        end else if (latch_q) begin
            // Latch high overrides every state and swallows any coincident clock edge.
            state     <= LATCHED;
            shreg     <= ~btn_input;
            SNES_Data <= ~btn_input[0];
            bit_index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    SNES_Data <= 1'b1;
                    bit_index <= '0;
                end
                LATCHED: begin
                    state     <= SHIFT;
                    bit_index <= '0;
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        shreg     <= {1'b1, shreg[15:1]};
                        bit_index <= bit_index + 5'd1;
                        if (bit_index == 5'd15) begin
                            state      <= DONE;
                            SNES_Data  <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            SNES_Data <= shreg[1];
                        end
                    end
                end
                DONE: begin
                    SNES_Data <= 1'b0;
                    bit_index <= 5'd16;
                end
                default: begin
                    state     <= IDLE;
                    SNES_Data <= 1'b1;
                    bit_index <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snes_controller_emulator.sv
// Self-checking bench for snes_controller_emulator: randomized frames against a bit-list model.
module tb_snes_controller_emulator;

    localparam int SYNC = 2;
    localparam int TMO  = 1000;

    logic        clk_100M = 1'b0;
    logic        rst = 1'b1;
    logic        SNES_Latch = 1'b0;
    logic        SNES_clk_1 = 1'b0;
    logic [15:0] btn_input = '0;
    logic        SNES_Data;
    logic        frame_done;
    logic [4:0]  bit_index;
    logic        link_active;

    int total = 0;
    int bad = 0;
    int fd_count = 0;

    snes_controller_emulator #(
        .SYNC_STAGES(SYNC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_100M(clk_100M),
        .rst(rst),
        .SNES_Latch(SNES_Latch),
        .SNES_clk_1(SNES_clk_1),
        .btn_input(btn_input),
        .SNES_Data(SNES_Data),
        .frame_done(frame_done),
        .bit_index(bit_index),
        .link_active(link_active)
    );

    always #5 clk_100M = ~clk_100M;

    always @(negedge clk_100M) begin
        if (frame_done === 1'b1) fd_count++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100M);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Console view: a stream of active-low bits, bit 0 first, sampled just before each rising clock.
    task automatic start_frame(input logic [15:0] btn, input bit clk_in_latch);
        btn_input  = btn;
        SNES_Latch = 1'b1;
        tick($urandom_range(8, 14));
        if (clk_in_latch) begin
            SNES_clk_1 = 1'b1;
            tick(6);
            SNES_clk_1 = 1'b0;
            tick(6);
        end
        check("latched_data", {31'd0, SNES_Data}, {31'd0, ~btn[0]});
        check("latched_index", {27'd0, bit_index}, 32'd0);
        SNES_Latch = 1'b0;
        tick(6);
    endtask

    task automatic shift_bits(input logic [15:0] exp_bits, input int first, input int n,
                              input logic [15:0] btn_mid);
        btn_input = btn_mid;
        for (int i = first; i < first + n; i++) begin
            tick($urandom_range(6, 12));
            check("stream_bit", {31'd0, SNES_Data}, {31'd0, exp_bits[i]});
            check("stream_index", {27'd0, bit_index}, i);
            SNES_clk_1 = 1'b1;
            tick($urandom_range(6, 12));
            SNES_clk_1 = 1'b0;
        end
    endtask

    task automatic check_done(input int fd_before);
        tick(8);
        check("done_data", {31'd0, SNES_Data}, 32'd0);
        check("done_index", {27'd0, bit_index}, 32'd16);
        check("frame_done_pulses", fd_count - fd_before, 32'd1);
    endtask

    task automatic full_frame(input logic [15:0] btn, input logic [15:0] btn_mid, input bit clk_in_latch);
        int fd0;
        start_frame(btn, clk_in_latch);
        fd0 = fd_count;
        shift_bits(~btn, 0, 16, btn_mid);
        check_done(fd0);
    endtask

    initial begin
        int fd0;
        logic [15:0] r;

        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset_data", {31'd0, SNES_Data}, 32'd1);
        check("reset_index", {27'd0, bit_index}, 32'd0);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
`ifdef SNES_EMU_TIMEOUT_EN
        check("reset_link", {31'd0, link_active}, 32'd0);
`else
        check("reset_link", {31'd0, link_active}, 32'd1);
`endif

        // Clock pulses without a latch must leave the idle output alone.
        SNES_clk_1 = 1'b1;
        tick(8);
        SNES_clk_1 = 1'b0;
        tick(8);
        check("idle_data", {31'd0, SNES_Data}, 32'd1);
        check("idle_index", {27'd0, bit_index}, 32'd0);

        // Single button 0 pressed, with an exact-latency check on the first shift.
        start_frame(16'h0001, 1'b0);
        fd0 = fd_count;
        SNES_clk_1 = 1'b1;
        tick(SYNC + 1);
        check("latency_before", {31'd0, SNES_Data}, 32'd0);
        tick(1);
        check("latency_after", {31'd0, SNES_Data}, 32'd1);
        check("latency_index", {27'd0, bit_index}, 32'd1);
        tick(6);
        SNES_clk_1 = 1'b0;
        shift_bits(~16'h0001, 1, 15, 16'h0001);
        check_done(fd0);
        check("link_after_frame", {31'd0, link_active}, 32'd1);

        full_frame(16'hA5C3, $urandom, 1'b0);
        full_frame(16'hFFFF, 16'h0000, 1'b1);

        for (int k = 0; k < 4; k++) begin
            r = $urandom;
            full_frame(r, $urandom, $urandom_range(0, 1) == 1);
        end

        // Partial frame abandoned by a new latch, then a frame with only button 15.
        r = $urandom;
        fd0 = fd_count;
        start_frame(r, 1'b0);
        shift_bits(~r, 0, 7, $urandom);
        full_frame(16'h8000, $urandom, 1'b0);
        check("partial_no_pulse", fd_count - fd0, 32'd1);

        // Reset mid-frame: no pulse, and clocks alone must not restart shifting.
        r = $urandom;
        fd0 = fd_count;
        start_frame(r, 1'b0);
        shift_bits(~r, 0, 5, r);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_data", {31'd0, SNES_Data}, 32'd1);
        check("rst_index", {27'd0, bit_index}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            SNES_clk_1 = 1'b1;
            tick(8);
            SNES_clk_1 = 1'b0;
            tick(8);
        end
        check("rst_idle_data", {31'd0, SNES_Data}, 32'd1);
        check("rst_idle_index", {27'd0, bit_index}, 32'd0);
        check("rst_no_pulse", fd_count - fd0, 32'd0);

        // Latch absence after a completed frame.
        full_frame($urandom, $urandom, 1'b0);
        check("link_before_quiet", {31'd0, link_active}, 32'd1);
        tick(TMO + 100);
`ifdef SNES_EMU_TIMEOUT_EN
        check("quiet_link", {31'd0, link_active}, 32'd0);
        check("quiet_data", {31'd0, SNES_Data}, 32'd1);
        check("quiet_index", {27'd0, bit_index}, 32'd0);
`else
        check("quiet_link", {31'd0, link_active}, 32'd1);
        check("quiet_data", {31'd0, SNES_Data}, 32'd0);
        check("quiet_index", {27'd0, bit_index}, 32'd16);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/snes_controller_emulator.md
SNES_CONTROLLER_EMULATOR -- requirements
Module: snes_controller_emulator

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on SNES_Latch and SNES_clk_1, legal range 2..4.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000: latch-absence limit (20 ms at 100 MHz), used only with SNES_EMU_TIMEOUT_EN.
REQ-003 SHALL have port clk_100M, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port SNES_Latch, input, 1 bit: console latch, asynchronous to clk_100M.
REQ-006 SHALL have port SNES_clk_1, input, 1 bit: console serial clock, asynchronous to clk_100M.
REQ-007 SHALL have port btn_input, input, 16 bits: button states, 1 = pressed; bit 0 is shifted first.
REQ-008 SHALL have port SNES_Data, output, 1 bit: registered serial data, active-low (pressed = 0).
REQ-009 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a 16-bit frame completes.
REQ-010 SHALL have port bit_index, output, 5 bits: index of the bit currently driven, 0..16.
REQ-011 SHALL have port link_active, output, 1 bit: console activity status.

Function
REQ-012 SHALL pass SNES_Latch and SNES_clk_1 through SYNC_STAGES flops, then one edge-detect flop; logic acts only on the synchronized edges.
REQ-013 SHALL update SNES_Data exactly SYNC_STAGES+1 clk_100M cycles after the first clk_100M edge that samples a new pin level.
REQ-014 SHALL implement states IDLE, LATCHED, SHIFT, DONE.
REQ-015 IDLE: SNES_Data = 1, bit_index = 0; clock edges ignored; synchronized latch high -> LATCHED.
REQ-016 LATCHED, while latch is high: reload the 16-bit shift register from ~btn_input every cycle (transparent load); SNES_Data = ~btn_input[0]; bit_index = 0.
REQ-017 Latch falling edge in LATCHED: freeze the shift register -> SHIFT; bit_index = 0.
REQ-018 SHIFT: each synchronized SNES_clk_1 rising edge shifts right by one and increments bit_index; SNES_Data presents the bit at bit_index.
REQ-019 SHIFT: the rising edge that takes bit_index from 15 to 16 -> DONE; SNES_Data = 0; frame_done high for exactly that one cycle.
REQ-020 DONE: SNES_Data held 0; further clock edges ignored; bit_index stays 16.
REQ-021 Synchronized latch high in any state SHALL force LATCHED on the next cycle, abandoning any partial frame.
REQ-022 Latch rising edge coincident with a clock rising edge: latch wins and the clock edge is discarded.
REQ-023 Clock edges while latch is high SHALL NOT shift.
REQ-024 Changes to btn_input after the latch falls SHALL NOT affect the frame in progress.

Reset
REQ-025 rst SHALL, on the next clk_100M edge, force state IDLE, SNES_Data 1, frame_done 0, bit_index 0, shift register all-ones, synchronizer flops 0, timeout counter 0.
REQ-026 rst asserted mid-frame SHALL abandon the frame with no frame_done pulse; after rst deasserts, the next latch high is required before any data is shifted.
REQ-027 link_active SHALL reset to 0 when SNES_EMU_TIMEOUT_EN is defined, and to 1 otherwise.

Configuration
REQ-028 With macro SNES_EMU_TIMEOUT_EN defined: a counter clears on each synchronized latch rising edge, otherwise increments and saturates at TIMEOUT_CYCLES.
REQ-029 With SNES_EMU_TIMEOUT_EN, link_active SHALL be 1 from the first latch rising edge until the counter reaches TIMEOUT_CYCLES; at that point link_active = 0 and the state returns to IDLE.
REQ-030 Without SNES_EMU_TIMEOUT_EN: no counter is built, link_active is constant 1, and a frame in DONE remains in DONE until the next latch.

Verification
REQ-031 Set btn_input=16'h0001, latch 12 us, then 16 clock pulses at 6 us low / 6 us high -> serial stream 0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1; after the 16th rising edge SNES_Data=0 and frame_done pulses once.
REQ-032 Set btn_input=16'hA5C3 and run a full frame -> the captured stream equals ~16'hA5C3, LSB first; bit_index steps 0..16.
REQ-033 After the latch falls, change btn_input from 16'hFFFF to 16'h0000 mid-frame -> all 16 bits read 0 (the pressed-level value loaded from 16'hFFFF), no corruption.
REQ-034 Raise latch after 7 clocks, then run a new frame with btn_input=16'h8000 -> the partial frame produces no frame_done; the new frame shifts bit 15 = 0; rst pulsed after 5 clocks -> SNES_Data=1, bit_index=0.
REQ-035 With SNES_EMU_TIMEOUT_EN and TIMEOUT_CYCLES=1000: one latch, then none for 1000 cycles -> link_active goes 1 then 0 and the state returns to IDLE; without the macro, link_active stays 1.
